booth_r4_iter_mul: RTL
======================

// Module: booth_r4_iter_mul
// PURPOSE
//  Iterative radix-4 Booth multiplier: the multi-cycle, parametrised successor of the combinational partial-product unit.
//  - Recodes the multiplier into Booth digits {-2,-1,0,+1,+2}.
//  - Generates PP_PER_CYCLE partial products per cycle and accumulates them into a 2*WIDTH product.
//  - Sits between the operand-issue stage and the result writeback, with valid/ready on both sides.
// PARAMETERS
//  WIDTH         16  operand width in bits; even, >=4
//  PP_PER_CYCLE  1   Booth digits consumed per iteration; 1 or 2
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block can accept operands
//  in_a       in   WIDTH    multiplicand
//  in_b       in   WIDTH    multiplier (Booth-recoded)
//  in_uns     in   1        treat operands as unsigned; present only with BOOTH_UNSIGNED_EN
//  out_valid  out  1        product valid
//  out_ready  in   1        consumer accepts product
//  out_p      out  2*WIDTH  product
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=IDLE, in_ready=1, out_valid=0, out_p=0, all internal registers 0.
//    Reset mid-operation discards the operation; no output is produced for it.
//  - FSM states:
//    - IDLE: in_ready=1. On in_valid&in_ready: latch A and B, clear acc, set cnt=0, go to CALC.
//    - CALC: in_ready=0. Each cycle adds PP_PER_CYCLE digits to acc, cnt+=PP_PER_CYCLE.
//      After the last digit, load out_p=acc (final), assert out_valid, go to DONE.
//    - DONE: out_valid=1, out_p held stable. On out_ready, clear out_valid and return to IDLE.
//      in_ready stays 0 in DONE; accept and deliver never overlap.
//  - NDIG = WIDTH/2, or WIDTH/2+1 with BOOTH_UNSIGNED_EN.
//    NIT = ceil(NDIG/PP_PER_CYCLE) CALC cycles.
//    out_valid rises exactly NIT cycles after the accept edge (WIDTH=16, PP=1: 8 cycles).
//  - Throughput: one product per NIT+2 cycles when out_ready=1.
//  - Digit i uses triple {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0:
//    000/111 -> 0;  001/010 -> +A;  011 -> +2A;  100 -> -2A;  101/110 -> -A.
//  - Partial product arithmetic:
//    - A is sign-extended to WIDTH+1; 2A is a left shift by 1.
//    - Negation is bitwise invert plus 1, performed within the PP, so there is no separate correction row.
//    - The PP is sign-extended to 2*WIDTH, shifted left by 2i, and added to acc modulo 2^(2*WIDTH).
//  - Digits indexed beyond the padded multiplier are 0 (pad bits = sign, or zero when unsigned).
//  - If out_valid=1 and in_valid=1 simultaneously, the input waits; it is accepted on the first IDLE cycle.
//  - in_a/in_b are sampled only at the accept edge; later changes have no effect.
// CONFIGURATION
//  BOOTH_UNSIGNED_EN defined:
//  - in_uns port exists and is latched at accept.
//  - With in_uns=1, A and B are zero-extended by 2 bits; otherwise they are sign-extended.
//  - NDIG = WIDTH/2+1 for every operation, signed or unsigned.
//  BOOTH_UNSIGNED_EN undefined:
//  - No in_uns port; operands are always two's complement.
//  - NDIG = WIDTH/2.
// TESTING
//  - 3 * 5, out_ready=1 -> out_p=0x0000000F; out_valid rises 8 cycles after accept (WIDTH=16, PP=1).
//  - 0xFFFF * 0xFFFF signed -> 0x00000001.
//  - 0x8000 * 0x8000 -> 0x40000000.
//  - 0x7FFF * 0x8000 -> 0xC0008000.
//  - Backpressure: hold out_ready=0 for 5 cycles -> out_p/out_valid stable, in_ready=0.
//    Release -> IDLE next cycle, in_ready=1.
//  - Reset pulse during cycle 4 of CALC -> out_valid=0, in_ready=1 immediately.
//    A new operation 2 * -3 then yields 0xFFFFFFFA.
//  - BOOTH_UNSIGNED_EN, in_uns=1, 0xFFFF * 0xFFFF -> 0xFFFE0001, with 9 CALC cycles.
//    Repeat with PP_PER_CYCLE=2 -> 5 CALC cycles.

Source files
------------

// File: rtl/booth_r4_iter_mul.sv
// rtl/booth_r4_iter_mul.sv - iterative radix-4 Booth multiplier with valid/ready handshakes
// Optional unsigned support (in_uns port) is built when BOOTH_UNSIGNED_EN is defined.
module booth_r4_iter_mul #(
    parameter int WIDTH        = 16,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
`ifdef BOOTH_UNSIGNED_EN
    input  logic               in_uns,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int PW = 2 * WIDTH;
`ifdef BOOTH_UNSIGNED_EN
    localparam int NDIG = WIDTH / 2 + 1;
`else
    localparam int NDIG = WIDTH / 2;
`endif
    localparam int NIT = (NDIG + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    // Recoding window: b[-1] at bit 0, then the multiplier, then pad bits covering every digit consumed.
    localparam int BXW = 2 * NIT * PP_PER_CYCLE + 3;
    localparam int CW  = $clog2(NDIG + PP_PER_CYCLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [PW-1:0]   out_p_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   m_q;
    logic [BXW-1:0]  bx_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            uns_w;
    logic            a_pad;
    logic            b_pad;
    logic [PW-1:0]   a_ext;
    logic [BXW-1:0]  b_ext;

`ifdef BOOTH_UNSIGNED_EN
    assign uns_w = in_uns;
`else
    assign uns_w = 1'b0;
`endif

    assign a_pad = uns_w ? 1'b0 : in_a[WIDTH-1];
    assign b_pad = uns_w ? 1'b0 : in_b[WIDTH-1];
    assign a_ext = {{WIDTH{a_pad}}, in_a};
    assign b_ext = {{(BXW-WIDTH-1){b_pad}}, in_b, 1'b0};

    // Multiplicand is pre-shifted by the digit weight, so negation here is directly the PP's two's complement.
    function automatic logic [PW-1:0] booth_pp(input logic [2:0] trip, input logic [PW-1:0] m);
        case (trip)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m << 1;
            3'b100:         booth_pp = ~(m << 1) + PW'(1);
            3'b101, 3'b110: booth_pp = ~m + PW'(1);
            default:        booth_pp = '0;
        endcase
    endfunction

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            acc_d = acc_d + booth_pp(bx_q[2*k +: 3], m_q << (2*k));
        end
    end

    assign cnt_d = cnt_q + CW'(PP_PER_CYCLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            acc_q       <= '0;
            m_q         <= '0;
            bx_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q        <= a_ext;
                        bx_q       <= b_ext;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    m_q   <= m_q << (2 * PP_PER_CYCLE);
                    bx_q  <= bx_q >> (2 * PP_PER_CYCLE);
                    cnt_q <= cnt_d;
                    if (cnt_d >= CW'(NDIG)) begin
                        out_p_q     <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;

endmodule
